// File: rtl/ram4k_arbiter_pkg.sv
// Shared definitions for the ram4k access arbiter: default widths, FSM states
// and requester indices.
package ram4k_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic with a registered preference pointer; round-robin by
// default, or requester 0 always wins when PRIO_FIXED is nonzero.
module rr_arbiter2
  import ram4k_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr names the requester that wins the next tie; it only moves on a grant.
  logic ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'(REQ_CPU);
    end else if (gnt0) begin
      ptr <= 1'(REQ_AUX);
    end else if (gnt1) begin
      ptr <= 1'(REQ_CPU);
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        if ((PRIO_FIXED != 0) || (ptr == 1'(REQ_CPU))) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

endmodule

// File: rtl/ram4k_arbiter.sv
// Two-requester access controller for a single ram4k. Defining RAM4K_ARB_CLEAR_EN
// adds a post-reset sweep that zeroes every RAM word before serving requests.
module ram4k_arbiter
  import ram4k_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic              busy
);

  arb_state_t state, state_nxt;
  logic       serving;

`ifdef RAM4K_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  // Reset parks the FSM in CLEAR with the sweep counter at word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_SERVE;
      ST_SERVE: state_nxt = ST_SERVE;
      default:  state_nxt = ST_SERVE;
    endcase
  end

  assign busy = (state == ST_CLEAR);
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SERVE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_SERVE;
  end

  assign busy = 1'b0;
`endif

  // No grant may appear while reset is held or the RAM is being swept.
  assign serving = (state == ST_SERVE) && !reset;

  rr_arbiter2 #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .en   (serving),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Requester 0 owns the RAM bus when idle; reset overrides everything so a
  // half-finished write can never land.
  always_comb begin
    mem_address = addr0;
    mem_in      = wdata0;
    mem_load    = (gnt0 & we0) | (gnt1 & we1);
    if (gnt1) begin
      mem_address = addr1;
      mem_in      = wdata1;
    end
`ifdef RAM4K_ARB_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem_address = clr_cnt;
      mem_in      = '0;
      mem_load    = 1'b1;
    end
`endif
    if (reset) begin
      mem_address = '0;
      mem_in      = '0;
      mem_load    = 1'b0;
    end
  end

  // Read data is captured on the granting edge and flagged for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) begin
        rdata0 <= mem_out;
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem_out;
      end
    end
  end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter: a round-robin and a fixed-priority instance,
// each with its own RAM model, checked against a shadow memory and read queues.
module tb_ram4k_arbiter;
  import ram4k_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  logic          gnt0, gnt1, rvalid0, rvalid1, mem_load, busy;
  logic [DW-1:0] rdata0, rdata1, mem_in, mem_out;
  logic [AW-1:0] mem_address;

  logic          f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_mem_load, f_busy;
  logic [DW-1:0] f_rdata0, f_rdata1, f_mem_in, f_mem_out;
  logic [AW-1:0] f_mem_address;

  logic [DW-1:0] ram    [4096];
  logic [DW-1:0] ram_f  [4096];
  logic [DW-1:0] shadow [4096];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ram4k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_FIXED(0)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_out(mem_out), .mem_in(mem_in), .mem_address(mem_address),
    .mem_load(mem_load), .busy(busy)
  );

  ram4k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_FIXED(1)) u_fix (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
    .mem_out(f_mem_out), .mem_in(f_mem_in), .mem_address(f_mem_address),
    .mem_load(f_mem_load), .busy(f_busy)
  );

  // RAM models: synchronous write, combinational read.
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  always @(posedge clk) if (f_mem_load) ram_f[f_mem_address] <= f_mem_in;
  assign mem_out   = ram[mem_address];
  assign f_mem_out = ram_f[f_mem_address];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each read granted one cycle earlier must show up as an rvalid pulse now.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW-1:0] exp;
      checkOutput("rvalid0", 32'(rvalid0), 32'(q0.size() != 0));
      if (q0.size() != 0) begin
        exp = q0.pop_front();
        checkOutput("rdata0", 32'(rdata0), 32'(exp));
      end
      checkOutput("rvalid1", 32'(rvalid1), 32'(q1.size() != 0));
      if (q1.size() != 0) begin
        exp = q1.pop_front();
        checkOutput("rdata1", 32'(rdata1), 32'(exp));
      end
    end
  end

  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // One cycle: check grants, record expected effects, then advance to the next negedge.
  task automatic applyStimulus(input logic eg0, input logic eg1);
    #1;
    checkOutput("gnt0", 32'(gnt0), 32'(eg0));
    checkOutput("gnt1", 32'(gnt1), 32'(eg1));
    checkOutput("fix_gnt0", 32'(f_gnt0), 32'(req0));
    checkOutput("fix_gnt1", 32'(f_gnt1), 32'(req1 & ~req0));
    checkOutput("mem_load", 32'(mem_load), 32'((eg0 & we0) | (eg1 & we1)));
    if (eg0) begin
      if (we0) shadow[addr0] = wdata0;
      else     q0.push_back(shadow[addr0]);
    end
    if (eg1) begin
      if (we1) shadow[addr1] = wdata1;
      else     q1.push_back(shadow[addr1]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    mon_en = 1'b0;
    q0.delete();
    q1.delete();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
`ifdef RAM4K_ARB_CLEAR_EN
    begin
      int hi = 0;
      int gseen = 0;
      #1;
      while (busy && hi < 5000) begin
        if (gnt0 || gnt1 || f_gnt0 || f_gnt1) gseen++;
        hi++;
        @(negedge clk);
        #1;
      end
      checkOutput("clear_len", 32'(hi), 32'd4096);
      checkOutput("clear_gnt", 32'(gseen), 32'd0);
      for (int i = 0; i < 4096; i++) shadow[i] = '0;
    end
`endif
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = '0;
      ram_f[i]  = '0;
      shadow[i] = '0;
    end

    // Reset values, with a write request pending that must not get through.
    #1 reset = 1'b1;
    drive0(1'b1, 1'b1, 12'h123, 16'hFFFF);
    #2;
    checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
    checkOutput("rst_load", 32'(mem_load), 32'd0);
    checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("rst_rvalid1", 32'(rvalid1), 32'd0);
    checkOutput("rst_rdata0", 32'(rdata0), 32'd0);
    checkOutput("rst_rdata1", 32'(rdata1), 32'd0);
    checkOutput("rst_addr", 32'(mem_address), 32'd0);
    checkOutput("rst_in", 32'(mem_in), 32'd0);
`ifndef RAM4K_ARB_CLEAR_EN
    checkOutput("rst_busy", 32'(busy), 32'd0);
`endif
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    doReset();

    // Requester 0: write then read back the same word.
    drive0(1'b1, 1'b1, 12'h0A5, 16'h1234);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b1, 1'b0, 12'h0A5, '0);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);

    // Requester 1 alone, leaving the pointer preferring requester 0.
    drive1(1'b1, 1'b0, 12'h0A5, '0);
    applyStimulus(1'b0, 1'b1);

    // Both requesting: round-robin alternates, fixed priority holds requester 0.
    drive0(1'b1, 1'b1, 12'hFFF, 16'hBEEF);
    drive1(1'b1, 1'b0, 12'hFFF, '0);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b1, 1'b0, 12'h0A5, '0);
    applyStimulus(1'b0, 1'b1);
    drive1(1'b1, 1'b0, 12'h0A5, '0);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b1, 1'b0, 12'hFFF, '0);
    applyStimulus(1'b0, 1'b1);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 12'hFFF, '0);
    applyStimulus(1'b0, 1'b1);
    drive1(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);

    // Requester 1 streams ten writes then ten reads with no competitor.
    for (int i = 0; i < 10; i++) begin
      drive1(1'b1, 1'b1, 12'h100 + 12'(i), 16'h1000 + 16'(i * 'h111));
      applyStimulus(1'b0, 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      drive1(1'b1, 1'b0, 12'h100 + 12'(i), '0);
      applyStimulus(1'b0, 1'b1);
    end
    drive1(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);

    // Reset lands while requester 1 has a write to 0x300 granted.
    drive0(1'b1, 1'b0, 12'h0A5, '0);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b1, 12'h300, 16'h5555);
    #2;
    checkOutput("mid_gnt1", 32'(gnt1), 32'd1);
    checkOutput("mid_load", 32'(mem_load), 32'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_load", 32'(mem_load), 32'd0);
    checkOutput("mid_rst_gnt1", 32'(gnt1), 32'd0);
    checkOutput("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("mid_rst_rdata0", 32'(rdata0), 32'd0);
    checkOutput("mid_rst_rdata1", 32'(rdata1), 32'd0);
    checkOutput("mid_rst_addr", 32'(mem_address), 32'd0);
    drive1(1'b0, 1'b0, '0, '0);
    doReset();

    // Pointer is back at requester 0, and 0x300 still holds its old value.
    drive0(1'b1, 1'b0, 12'h0A5, '0);
    drive1(1'b1, 1'b0, 12'h300, '0);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1);
    drive1(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);

`ifdef RAM4K_ARB_CLEAR_EN
    // Preloaded word must be swept to zero by the post-reset clear.
    drive0(1'b1, 1'b1, 12'h7FF, 16'hAAAA);
    applyStimulus(1'b1, 1'b0);
    drive0(1'b1, 1'b0, 12'h7FF, '0);
    doReset();
    applyStimulus(1'b1, 1'b0);
    drive0(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram4k_arbiter.md
Name: ram4k_arbiter

Overview:
- Two-requester access controller for one shared ram4k (16-bit word, 12-bit address, synchronous write, combinational read).
- Serves at most one access per clk cycle.
- Picks the winner round-robin or fixed-priority, drives the RAM's in/address/load, and returns registered read data with a valid pulse.
- Sits between the CPU data port (requester 0) and a secondary master such as a screen/DMA engine (requester 1).

Parameters:
- ADDR_W, 12, RAM address width (4096 words).
- DATA_W, 16, RAM word width.
- PRIO_FIXED, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 granted this cycle.
- rvalid0  out  1  requester 0 read data valid.
- rdata0  out  DATA_W  requester 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above for requester 1.
- mem_out  in  DATA_W  RAM read data (ram4k out).
- mem_in  out  DATA_W  RAM write data (ram4k in).
- mem_address  out  ADDR_W  RAM address (ram4k address).
- mem_load  out  1  RAM write enable (ram4k load).
- busy  out  1  high while the clear sequence runs (feature only; else tied 0).

Behaviour:
- Reset values:
  - gnt0 = gnt1 = rvalid0 = rvalid1 = mem_load = 0; rdata0 = rdata1 = 0.
  - mem_address = 0; mem_in = 0; priority pointer = requester 0.
- While reset is high, mem_load is forced 0 combinationally, so no RAM write can occur.
- Handshake:
  - A requester raises req and holds req/we/addr/wdata stable until it samples gnt = 1 at a rising edge. The request completes on that edge.
  - It may then drop req, or keep it high to issue a new access the next cycle.
- Grant is combinational from the req inputs and the registered pointer. At most one gnt is high per cycle; no grant without a req.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting, PRIO_FIXED=1: requester 0 wins.
  - Both requesting, PRIO_FIXED=0: the requester not granted most recently wins. The pointer updates only on a granted cycle; an idle cycle leaves it unchanged.
- Memory drive:
  - mem_address/mem_in mux the granted requester's addr/wdata. With no grant they hold requester 0's values.
  - mem_load = gnt & we of the winner.
- Write: the RAM updates on the granting edge.
- Read:
  - mem_out is sampled into the winner's rdata register on the granting edge.
  - That requester's rvalid is high for exactly the following cycle (latency 1).
  - rdata holds its value until the next read for that requester.
- Back-to-back: one access per cycle per winner. A streaming requester with the other idle gets 100% bandwidth.
- Read-after-write to the same address on consecutive grants returns the new data.
- Reset mid-access: the in-flight grant is abandoned, rvalid is cleared, the pointer returns to requester 0, and no write is committed.

Optional Feature:
- Macro: RAM4K_ARB_CLEAR_EN.
- Defined: after reset deassertion the FSM enters CLEAR.
  - Each cycle it drives mem_load=1, mem_in=0, mem_address=counter, for 4096 cycles (0 to 4095).
  - busy=1 and gnt0=gnt1=0 throughout CLEAR.
  - When the counter wraps, the FSM moves to SERVE and busy=0 on the next cycle.
  - Reset during CLEAR restarts the counter at 0.
- Undefined: the FSM resets directly into SERVE, busy is constant 0, and there is no counter.

Decomposition:
- Shared package:
  - ADDR_W/DATA_W defaults.
  - FSM state encoding (ST_SERVE, ST_CLEAR).
  - Requester index constants (REQ_CPU=0, REQ_AUX=1).
- Natural sub-module: rr_arbiter2. This is the two-input grant logic plus pointer register, parameterized by PRIO_FIXED. The top module holds the muxes, read-data registers and clear FSM.

Test Plan:
- Requester 0 writes 0x1234 to 0x0A5, then reads 0x0A5 -> gnt0 on both cycles; rvalid0 one cycle after the read grant with rdata0=0x1234; gnt1 stays 0.
- Both request every cycle, PRIO_FIXED=0 -> grants alternate 0,1,0,1; requester 1 reads 0xFFF after requester 0 wrote 0xBEEF there -> rdata1=0xBEEF.
- Both request, PRIO_FIXED=1 -> gnt0 every cycle, gnt1 never, until req0 drops; then gnt1 in the same cycle.
- Reset asserted mid-cycle while requester 1 has a write granted to 0x300 (old 0x0000) -> mem_load falls immediately; a later read of 0x300 returns 0x0000; all outputs at reset values.
- With RAM4K_ARB_CLEAR_EN: preload 0x7FF=0xAAAA, pulse reset -> busy for exactly 4096 cycles with no grants; then a read of 0x7FF returns 0x0000.
- Requester 1 holds req with no competitor for 10 cycles of reads at incrementing addresses -> 10 consecutive gnt1 and 10 rvalid1 pulses, each delayed by 1 cycle.
